// File: rtl/tomasulo_pkg.sv
// Shared types and sizing for the Tomasulo core: reorder buffer entries and the
// common data bus broadcast record.
package tomasulo_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ROB_DEPTH  = 8;
  localparam int unsigned ROB_TAG_W  = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } rob_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      data;
  } cdb_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, collects CDB results and
// retires completed entries in program order into the architectural register file.
module reorder_buffer
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH = ROB_DEPTH,
  parameter int unsigned TAG_W = $clog2(DEPTH),
  parameter int unsigned XLEN  = tomasulo_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  disp_valid,
  input  logic [REG_ADDR_W-1:0] disp_rd,
  output logic                  disp_ready,
  output logic [TAG_W-1:0]      disp_tag,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [XLEN-1:0]       cdb_data,
  input  logic [TAG_W-1:0]      q_tag1,
  input  logic [TAG_W-1:0]      q_tag2,
  output logic                  q_ready1,
  output logic                  q_ready2,
  output logic [XLEN-1:0]       q_data1,
  output logic [XLEN-1:0]       q_data2,
  output logic                  commit_we,
  output logic [REG_ADDR_W-1:0] commit_rd,
  output logic [XLEN-1:0]       commit_data,
  output logic [TAG_W-1:0]      commit_tag,
  output logic                  empty
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);

  rob_entry_t entries_q [DEPTH];
  rob_entry_t entries_d [DEPTH];

  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic                  commit_we_q;
  logic [REG_ADDR_W-1:0] commit_rd_q;
  logic [XLEN-1:0]       commit_data_q;
  logic [TAG_W-1:0]      commit_tag_q;

  rob_entry_t head_entry;
  logic       disp_fire;
  logic       commit_fire;

  assign head_entry  = entries_q[head_q];
  assign commit_fire = head_entry.valid & head_entry.done;

  // Readiness looks only at the current count; a same-edge retirement does not help.
  assign disp_ready = (count_q < FullCount);
  assign disp_fire  = disp_valid & disp_ready;
  assign disp_tag   = tail_q;
  assign empty      = (count_q == '0);

  assign q_ready1 = entries_q[q_tag1].valid & entries_q[q_tag1].done;
  assign q_ready2 = entries_q[q_tag2].valid & entries_q[q_tag2].done;
  assign q_data1  = entries_q[q_tag1].value;
  assign q_data2  = entries_q[q_tag2].value;

  assign commit_we   = commit_we_q;
  assign commit_rd   = commit_rd_q;
  assign commit_data = commit_data_q;
  assign commit_tag  = commit_tag_q;

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_d[i] = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // A broadcast to a free slot is stale and must not resurrect it.
      if (cdb_valid && entries_q[cdb_tag].valid) begin
        entries_d[cdb_tag].done  = 1'b1;
        entries_d[cdb_tag].value = cdb_data;
      end
      if (commit_fire) begin
        entries_d[head_q].valid = 1'b0;
        entries_d[head_q].done  = 1'b0;
        head_d = head_q + 1'b1;
      end
      // The tail slot is always free when dispatch fires, so no clash with the above.
      if (disp_fire) begin
        entries_d[tail_q].valid = 1'b1;
        entries_d[tail_q].done  = 1'b0;
        entries_d[tail_q].rd    = disp_rd;
        tail_d = tail_q + 1'b1;
      end
      case ({disp_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Registered so the register file can sample on the following falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_we_q   <= 1'b0;
      commit_rd_q   <= '0;
      commit_data_q <= '0;
      commit_tag_q  <= '0;
    end else if (flush) begin
      commit_we_q <= 1'b0;
    end else if (commit_fire) begin
      commit_we_q   <= (head_entry.rd != '0);
      commit_rd_q   <= head_entry.rd;
      commit_data_q <= head_entry.value;
      commit_tag_q  <= head_q;
    end else begin
      commit_we_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a vector table for the basic retire flow,
// hand sequences for full/wrap/flush/query/reset, and an in-order commit scoreboard.
module tb_reorder_buffer;
  import tomasulo_pkg::*;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             disp_valid;
  logic [4:0]       disp_rd;
  logic             disp_ready;
  logic [TAG_W-1:0] disp_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic [TAG_W-1:0] q_tag1, q_tag2;
  logic             q_ready1, q_ready2;
  logic [31:0]      q_data1, q_data2;
  logic             commit_we;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_data;
  logic [TAG_W-1:0] commit_tag;
  logic             empty;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_rd    (disp_rd),
    .disp_ready (disp_ready),
    .disp_tag   (disp_tag),
    .cdb_valid  (cdb_valid),
    .cdb_tag    (cdb_tag),
    .cdb_data   (cdb_data),
    .q_tag1     (q_tag1),
    .q_tag2     (q_tag2),
    .q_ready1   (q_ready1),
    .q_ready2   (q_ready2),
    .q_data1    (q_data1),
    .q_data2    (q_data2),
    .commit_we  (commit_we),
    .commit_rd  (commit_rd),
    .commit_data(commit_data),
    .commit_tag (commit_tag),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       rd;
    logic [TAG_W-1:0] tag;
  } sb_t;

  typedef struct {
    bit               fl;
    bit               dv;
    logic [4:0]       rd;
    bit               cv;
    logic [TAG_W-1:0] tg;
    logic [31:0]      d;
    bit               acc;
    bit               e_rdy;
    logic [TAG_W-1:0] e_dtag;
    bit               e_empty;
    bit               e_we;
    logic [4:0]       e_rd;
    logic [31:0]      e_data;
    logic [TAG_W-1:0] e_ctag;
  } vec_t;

  sb_t         sb_q[$];
  logic [31:0] val_m [DEPTH];
  int          m_tail;
  int          n_checks;
  int          n_errors;
  vec_t        tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural writes must appear in dispatch order with the broadcast data.
  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (rst_n && commit_we) begin
      while (sb_q.size() > 0 && sb_q[0].rd == 5'd0) void'(sb_q.pop_front());
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_commit: got tag %0d, expected no commit", commit_tag);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rd", 32'(commit_rd), 32'(e.rd));
        chk("sb_tag", 32'(commit_tag), 32'(e.tag));
        chk("sb_data", commit_data, val_m[e.tag]);
      end
    end
  end

  task automatic idle_inputs();
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_rd    = 5'd0;
    cdb_valid  = 1'b0;
    cdb_tag    = '0;
    cdb_data   = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    q_tag1 = '0;
    q_tag2 = '0;
    sb_q.delete();
    m_tail = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle of stimulus, let one rising edge pass, sample 1 time unit later.
  task automatic cyc(input bit fl, input bit dv, input logic [4:0] rd, input bit cv,
                     input logic [TAG_W-1:0] tg, input logic [31:0] d, input bit acc);
    flush = fl; disp_valid = dv; disp_rd = rd; cdb_valid = cv; cdb_tag = tg; cdb_data = d;
    if (fl) begin
      sb_q.delete();
      m_tail = 0;
    end else begin
      if (acc) begin
        chk("disp_tag_at_dispatch", 32'(disp_tag), 32'(m_tail));
        sb_q.push_back('{rd: rd, tag: TAG_W'(m_tail)});
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (cv) val_m[tg] = d;
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < DEPTH; i++) val_m[i] = 32'd0;

    // Basic flow: three dispatches, out-of-order completion, in-order retirement.
    tbl[0] = '{1'b0, 1'b1, 5'd5, 1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0};
    tbl[1] = '{1'b0, 1'b1, 5'd6, 1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0};
    tbl[2] = '{1'b0, 1'b1, 5'd7, 1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0};
    tbl[3] = '{1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 32'h22, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0};
    tbl[4] = '{1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h11, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 5'd0, 32'h0,  3'd0};
    tbl[5] = '{1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 5'd5, 32'h11, 3'd0};
    tbl[6] = '{1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 5'd6, 32'h22, 3'd1};
    tbl[7] = '{1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 32'h0,  1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 5'd6, 32'h22, 3'd1};

    rst_n = 1'b0;
    do_reset();
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_disp_tag", 32'(disp_tag), 32'd0);
    chk("rst_commit_we", 32'(commit_we), 32'd0);
    chk("rst_commit_rd", 32'(commit_rd), 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_commit_tag", 32'(commit_tag), 32'd0);
    chk("rst_q_ready1", 32'(q_ready1), 32'd0);

    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].fl, tbl[i].dv, tbl[i].rd, tbl[i].cv, tbl[i].tg, tbl[i].d, tbl[i].acc);
      chk($sformatf("v%0d_disp_ready", i), 32'(disp_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_disp_tag", i), 32'(disp_tag), 32'(tbl[i].e_dtag));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("v%0d_commit_we", i), 32'(commit_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_commit_rd", i), 32'(commit_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_commit_data", i), commit_data, tbl[i].e_data);
      chk($sformatf("v%0d_commit_tag", i), 32'(commit_tag), 32'(tbl[i].e_ctag));
    end
    q_tag1 = 3'd2;
    #1;
    chk("tag2_pending", 32'(q_ready1), 32'd0);

    // Full buffer, ignored dispatch, full-while-retiring rejection, wrap-around.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 5'(i + 1), 1'b0, '0, 32'd0, 1'b1);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_disp_tag", 32'(disp_tag), 32'd0);
    cyc(1'b0, 1'b1, 5'd9, 1'b0, '0, 32'd0, 1'b0);
    chk("ninth_disp_ready", 32'(disp_ready), 32'd0);
    chk("ninth_disp_tag", 32'(disp_tag), 32'd0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h100, 1'b0);
    chk("cdb_head_no_bypass_we", 32'(commit_we), 32'd0);
    cyc(1'b0, 1'b1, 5'd10, 1'b0, '0, 32'd0, 1'b0);
    chk("full_commit_we", 32'(commit_we), 32'd1);
    chk("full_commit_tag", 32'(commit_tag), 32'd0);
    chk("after_retire_ready", 32'(disp_ready), 32'd1);
    chk("full_reject_tag", 32'(disp_tag), 32'd0);
    cyc(1'b0, 1'b1, 5'd11, 1'b0, '0, 32'd0, 1'b1);
    chk("wrap_disp_tag", 32'(disp_tag), 32'd1);
    chk("wrap_full_again", 32'(disp_ready), 32'd0);
    for (int t = DEPTH - 1; t >= 1; t--) cyc(1'b0, 1'b0, 5'd0, 1'b1, TAG_W'(t), 32'h700 + 32'(t), 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'hB0B, 1'b0);
    for (int i = 0; i < 10; i++) idle();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // rd=0 retires silently but still frees its slot.
    do_reset();
    cyc(1'b0, 1'b1, 5'd0, 1'b0, '0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'hDEAD, 1'b0);
    chk("rd0_not_empty", 32'(empty), 32'd0);
    idle();
    chk("rd0_commit_we", 32'(commit_we), 32'd0);
    chk("rd0_commit_tag", 32'(commit_tag), 32'd0);
    chk("rd0_commit_data", commit_data, 32'hDEAD);
    chk("rd0_empty", 32'(empty), 32'd1);

    // Flush beats a same-edge CDB to the head.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'(i + 1), 1'b0, '0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd1, 32'hA1, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd2, 32'hA2, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 1'b1, 3'd0, 32'hA0, 1'b0);
    chk("flush_commit_we", 32'(commit_we), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_disp_tag", 32'(disp_tag), 32'd0);
    idle();
    chk("flush_no_late_commit", 32'(commit_we), 32'd0);
    cyc(1'b0, 1'b1, 5'd4, 1'b0, '0, 32'd0, 1'b1);
    q_tag1 = 3'd0;
    q_tag2 = 3'd1;
    #1;
    chk("flush_new_tag", 32'(disp_tag), 32'd1);
    chk("flush_new_pending", 32'(q_ready1), 32'd0);
    chk("flush_cleared_done", 32'(q_ready2), 32'd0);

    // Operand query: no same-cycle bypass; stale CDB to a free slot ignored.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5'(i + 1), 1'b0, '0, 32'd0, 1'b1);
    q_tag1 = 3'd3;
    q_tag2 = 3'd3;
    #1;
    chk("q_pending", 32'(q_ready1), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'hABCD;
    val_m[3] = 32'hABCD;
    #1;
    chk("q_no_bypass", 32'(q_ready1), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("q_ready1_after", 32'(q_ready1), 32'd1);
    chk("q_data1_after", q_data1, 32'hABCD);
    chk("q_data2_after", q_data2, 32'hABCD);
    q_tag2 = 3'd6;
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd6, 32'h77, 1'b0);
    chk("cdb_invalid_ignored", 32'(q_ready2), 32'd0);

    // Asynchronous reset clears registered commit outputs without a clock edge.
    do_reset();
    cyc(1'b0, 1'b1, 5'd9, 1'b0, '0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 5'd0, 1'b1, 3'd0, 32'h99, 1'b0);
    idle();
    chk("pre_async_we", 32'(commit_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_commit_we", 32'(commit_we), 32'd0);
    chk("async_commit_rd", 32'(commit_rd), 32'd0);
    chk("async_commit_data", commit_data, 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_disp_tag", 32'(disp_tag), 32'd0);
    chk("async_disp_ready", 32'(disp_ready), 32'd1);
    do_reset();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
